alu_seq: RTL and testbench

Parametrised, handshaked successor to the datapath ALU. It executes the existing op encodings in one cycle and adds an iterative multi-cycle multiply. Results sit in a one-entry output register, and an architectural NZVC flag register is updated only on request. It sits between the register-read stage and writeback in the multicycle datapath, with valid/ready on both sides.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_core.sv | 51 +++++
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op encodings, FSM states and the NZVC flag record
// for the handshaked sequential ALU (alu_seq).
// Optional multiply is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

   // Op select, identical to the datapath ALU; 3'b001 is reserved and runs as pass-B.
   typedef enum logic [2:0] {
      OP_PASSB = 3'b000,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_AND   = 3'b100,
      OP_OR    = 3'b101,
      OP_XOR   = 3'b110,
      OP_MUL   = 3'b111
   } op_e;

   // Control FSM states; MUL is only reachable when the multiplier is built.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Architectural condition flags.
   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational WIDTH-bit add/sub/logic unit.
// Subtraction is A + ~B + 1 so the carry outputs follow the ARM-style
// convention (C=1 means no borrow). Carries out of bit WIDTH-1 and
// WIDTH-2 are exported so the caller can form C and V.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry_msb,
   output logic             o_carry_msb_m1
);

   logic             w_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic             w_c_lo;
   logic             w_c_hi;

   assign w_sub   = (i_op == OP_SUB);
   assign w_b_eff = w_sub ? ~i_b : i_b;

   // Split the adder at the top bit so both carries needed for V are visible.
   assign {w_c_lo, w_sum[WIDTH-2:0]} = {1'b0, i_a[WIDTH-2:0]}
                                     + {1'b0, w_b_eff[WIDTH-2:0]}
                                     + {{(WIDTH-1){1'b0}}, w_sub};
   assign {w_c_hi, w_sum[WIDTH-1]}   = {1'b0, i_a[WIDTH-1]}
                                     + {1'b0, w_b_eff[WIDTH-1]}
                                     + {1'b0, w_c_lo};

   assign o_carry_msb    = w_c_hi;
   assign o_carry_msb_m1 = w_c_lo;

   // Result mux; pass, reserved and (here) multiply encodings all fall to B.
   always_comb begin
      o_result = i_b;
      case (i_op)
         OP_ADD,
         OP_SUB:  o_result = w_sum;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         default: o_result = i_b;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a one-entry result register and an NZVC flag
// register written only when the op was issued with set_flags=1.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier for
// op 111; otherwise op 111 is a single-cycle pass-B.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   state_e           r_state;
   logic [WIDTH-1:0] r_result;
   logic             r_out_valid;
   flags_t           r_flags;

   logic             w_accept;
   logic             w_accept_mul;
   logic [WIDTH-1:0] w_core_result;
   logic             w_c_msb;
   logic             w_c_msb_m1;
   flags_t           w_core_flags;

   // A drain and a new accept may share the same edge in DONE.
   assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
   assign w_accept = in_valid & in_ready;

   alu_seq_core #(.WIDTH(WIDTH)) u_core (
      .i_a            (A),
      .i_b            (B),
      .i_op           (cntrl),
      .o_result       (w_core_result),
      .o_carry_msb    (w_c_msb),
      .o_carry_msb_m1 (w_c_msb_m1)
   );

   // Flags for single-cycle ops; only add/sub produce carry and overflow.
   always_comb begin
      w_core_flags   = '0;
      w_core_flags.n = w_core_result[WIDTH-1];
      w_core_flags.z = (w_core_result == '0);
      if ((cntrl == OP_ADD) || (cntrl == OP_SUB)) begin
         w_core_flags.c = w_c_msb;
         w_core_flags.v = w_c_msb ^ w_c_msb_m1;
      end
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int CNT_W = $clog2(WIDTH + 1);

   // r_prod starts as {0, multiplier}; each step adds the multiplicand into
   // the upper half when the current LSB is set, then shifts right by one.
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mcand;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_set_flags;

   logic [WIDTH:0]     w_upper_sum;
   logic [2*WIDTH-1:0] w_prod_next;
   logic               w_mul_last;
   flags_t             w_mul_flags;

   assign w_accept_mul = w_accept & (cntrl == OP_MUL);
   assign w_upper_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
   assign w_prod_next  = r_prod[0] ? {w_upper_sum, r_prod[WIDTH-1:1]}
                                   : {1'b0, r_prod[2*WIDTH-1:1]};
   assign w_mul_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // Multiply flags from the final product: V flags a truncated high half.
   always_comb begin
      w_mul_flags   = '0;
      w_mul_flags.n = w_prod_next[WIDTH-1];
      w_mul_flags.z = (w_prod_next[WIDTH-1:0] == '0);
      w_mul_flags.v = |w_prod_next[2*WIDTH-1:WIDTH];
   end
`else
   assign w_accept_mul = 1'b0;
`endif

   // Control FSM with registered result, valid and flag outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_flags     <= '0;
`ifdef ALU_SEQ_MUL_EN
         r_prod      <= '0;
         r_mcand     <= '0;
         r_cnt       <= '0;
         r_set_flags <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE,
            DONE: begin
               if (w_accept_mul) begin
`ifdef ALU_SEQ_MUL_EN
                  r_state     <= MUL;
                  r_out_valid <= 1'b0;
                  r_prod      <= {{WIDTH{1'b0}}, B};
                  r_mcand     <= A;
                  r_cnt       <= '0;
                  r_set_flags <= set_flags;
`endif
               end else if (w_accept) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_core_result;
                  if (set_flags) begin
                     r_flags <= w_core_flags;
                  end
               end else if ((r_state == DONE) && out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               r_prod <= w_prod_next;
               r_cnt  <= r_cnt + 1'b1;
               if (w_mul_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_prod_next[WIDTH-1:0];
                  if (r_set_flags) begin
                     r_flags <= w_mul_flags;
                  end
               end
            end
`endif
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign negative  = r_flags.n;
   assign zero      = r_flags.z;
   assign overflow  = r_flags.v;
   assign carry_out = r_flags.c;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq
// (WIDTH=64). Multiply checks are built when ALU_SEQ_MUL_EN is defined,
// otherwise op 111 is checked as pass-B.
module tb_alu_seq;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [2:0]    cntrl = 3'b000;
   logic          set_flags = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          negative;
   logic          zero;
   logic          overflow;
   logic          carry_out;

   int n_total = 0;
   int n_bad   = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cntrl     (cntrl),
      .set_flags (set_flags),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .negative  (negative),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   // One line per comparison; counts everything that goes through it.
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   function automatic logic [W-1:0] nzvc();
      return {{(W-4){1'b0}}, negative, zero, overflow, carry_out};
   endfunction

   // Offer one op at a negedge; returns 1 time unit after the accept edge
   // with the operand inputs scrambled so late changes would show up.
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic sf);
      @(negedge clk);
      A = a; B = b; cntrl = op; set_flags = sf; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = 64'hDEAD_BEEF_0BAD_F00D; B = 64'h1357_9BDF_2468_ACE0;
      cntrl = 3'b110; set_flags = ~sf;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result",    result,             64'd0);
      chk("rst_flags",     nzvc(),             64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);

      // ADD signed overflow, out_valid one cycle after accept
      send(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      @(negedge clk);
      chk("add_valid",  {63'd0, out_valid}, 64'd1);
      chk("add_result", result, 64'h8000_0000_0000_0000);
      chk("add_nzvc",   nzvc(), 64'b1010);

      // SUB to zero sets Z and C (no borrow)
      send(3'b011, 64'd5, 64'd5, 1'b1);
      @(negedge clk);
      chk("sub_result", result, 64'd0);
      chk("sub_nzvc",   nzvc(), 64'b0101);

      // AND without set_flags leaves flags untouched
      send(3'b100, 64'hF0, 64'h0F, 1'b0);
      @(negedge clk);
      chk("and_result", result, 64'd0);
      chk("and_nzvc",   nzvc(), 64'b0101);

      // OR with set_flags clears Z and C
      send(3'b101, 64'hF0, 64'h0F, 1'b1);
      @(negedge clk);
      chk("or_result", result, 64'hFF);
      chk("or_nzvc",   nzvc(), 64'b0000);

      // Reserved encoding runs as pass-B
      send(3'b001, 64'h1111, 64'h55, 1'b0);
      @(negedge clk);
      chk("rsv_result", result, 64'h55);

      // Backpressure: SUB 2-3 held for 10 cycles
      @(negedge clk);
      out_ready = 1'b0;
      send(3'b011, 64'd2, 64'd3, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("bp_result_%0d", i),   result, 64'hFFFF_FFFF_FFFF_FFFF);
         chk($sformatf("bp_valid_%0d", i),    {63'd0, out_valid}, 64'd1);
         chk($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready},  64'd0);
      end
      chk("bp_nzvc", nzvc(), 64'b1000);
      // Drain and accept XOR on the same edge
      A = 64'hFF; B = 64'h0F; cntrl = 3'b110; set_flags = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("xor_result", result, 64'hF0);
      chk("xor_valid",  {63'd0, out_valid}, 64'd1);
      chk("xor_nzvc",   nzvc(), 64'b1000);

      // Reset while holding a result in DONE
      @(negedge clk);
      out_ready = 1'b0;
      send(3'b010, 64'd40, 64'd2, 1'b1);
      @(negedge clk);
      chk("done_pre_rst", result, 64'd42);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      chk("done_rst_valid",    {63'd0, out_valid}, 64'd0);
      chk("done_rst_result",   result, 64'd0);
      chk("done_rst_in_ready", {63'd0, in_ready}, 64'd1);

`ifdef ALU_SEQ_MUL_EN
      begin
         int n;
         // 3 x 5, latency WIDTH+1, in_ready low while iterating
         send(3'b111, 64'd3, 64'd5, 1'b1);
         n = 1;
         @(negedge clk);
         chk("mul_busy_in_ready", {63'd0, in_ready}, 64'd0);
         while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("mul_latency", 64'(n), 64'(W + 1));
         chk("mul_result",  result, 64'd15);
         chk("mul_nzvc",    nzvc(), 64'b0000);

         // All-ones x 2 truncates into the high half
         send(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
         n = 1;
         @(negedge clk);
         while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("mul2_latency", 64'(n), 64'(W + 1));
         chk("mul2_result",  result, 64'hFFFF_FFFF_FFFF_FFFE);
         chk("mul2_nzvc",    nzvc(), 64'b1010);

         // Reset at multiply cycle 10 discards everything
         send(3'b111, 64'd7, 64'd9, 1'b1);
         repeat (9) @(negedge clk);
         chk("mul_mid_valid", {63'd0, out_valid}, 64'd0);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         chk("mul_rst_valid",    {63'd0, out_valid}, 64'd0);
         chk("mul_rst_result",   result, 64'd0);
         chk("mul_rst_flags",    nzvc(), 64'd0);
         chk("mul_rst_in_ready", {63'd0, in_ready}, 64'd1);
         n = 0;
         for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid) n++;
         end
         chk("mul_rst_no_stale", 64'(n), 64'd0);
      end
`else
      // Op 111 is a single-cycle pass-B in this build
      send(3'b111, 64'd3, 64'h1234, 1'b1);
      @(negedge clk);
      chk("op7_valid",  {63'd0, out_valid}, 64'd1);
      chk("op7_result", result, 64'h1234);
      chk("op7_nzvc",   nzvc(), 64'b0000);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
